// File: rtl/nn_pkg.sv
// Shared constants for the binarized neuron datapath.
// State codes, ALU opcodes and the default accumulator width.
package nn_pkg;

  localparam int ACC_W = 12;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic ALU_OP_ADD1 = 1'b0;
  localparam logic ALU_OP_SUB1 = 1'b1;

endpackage

// File: rtl/neuron_seq_if.sv
// Input-pair and result handshakes of neuron_seq.
// master: pair source / result sink; slave: neuron_seq.
interface neuron_seq_if #(
  parameter int ACC_W = nn_pkg::ACC_W
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic                    in_x;
  logic                    in_w;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_data;

  modport master (
    output in_valid, in_x, in_w, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_x, in_w, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/neuron_seq.sv
// Sequencer + accumulator closing the loop around an add1/sub1 ALU.
// Ports: clk, rst_n, start, [bias], io (pairs/result), alu_*, busy.
// Macro NEURON_SEQ_BIAS_LOAD_EN adds bias preload on start.
module neuron_seq #(
  parameter int ACC_W = nn_pkg::ACC_W,
  parameter int N_IN  = 16,
  parameter int CNT_W = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
`ifdef NEURON_SEQ_BIAS_LOAD_EN
  input  logic signed [ACC_W-1:0] bias,
`endif
  neuron_seq_if.slave             io,
  output logic                    alu_in_a_lsb,
  output logic signed [ACC_W-1:0] alu_in_b,
  output logic                    alu_op,
  input  logic signed [ACC_W-1:0] alu_out,
  output logic                    busy
);

  import nn_pkg::*;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ACCUM = ST_ACCUM,
    S_DONE  = ST_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_IN - 1);

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic                    accept;
  logic signed [ACC_W-1:0] load_val;

`ifdef NEURON_SEQ_BIAS_LOAD_EN
  assign load_val = bias;
`else
  assign load_val = '0;
`endif

  assign accept = (state == S_ACCUM) && io.in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            acc   <= load_val;
            cnt   <= '0;
            state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (accept) begin
            acc <= alu_out;
            cnt <= cnt + 1'b1;
            if (cnt == LAST)
              state <= S_DONE;
          end
        end
        S_DONE: begin
          if (io.out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign io.in_ready  = (state == S_ACCUM);
  assign io.out_valid = (state == S_DONE);
  assign io.out_data  = io.out_valid ? acc : '0;
  assign busy         = (state != S_IDLE);

  // Mismatch of activation and weight subtracts; idle cycles park on add1.
  assign alu_in_a_lsb = 1'b1;
  assign alu_in_b     = acc;
  assign alu_op       = accept ? (io.in_x ^ io.in_w) : ALU_OP_ADD1;

endmodule

// File: tb/tb_neuron_seq.sv
// Randomized scoreboard bench for neuron_seq with an ALU model beside it.
// Uses N_IN=4; bias is exercised when NEURON_SEQ_BIAS_LOAD_EN is defined.
module tb_neuron_seq;

  localparam int W = 12;
  localparam int N = 4;

`ifdef NEURON_SEQ_BIAS_LOAD_EN
  localparam bit HAS_BIAS = 1'b1;
`else
  localparam bit HAS_BIAS = 1'b0;
`endif

  logic                clk;
  logic                rst_n;
  logic                start;
  logic signed [W-1:0] bias_v;
  logic                alu_in_a_lsb;
  logic signed [W-1:0] alu_in_b;
  logic                alu_op;
  logic signed [W-1:0] alu_out;
  logic                busy;

  neuron_seq_if #(.ACC_W(W)) nif ();

  neuron_seq #(.ACC_W(W), .N_IN(N), .CNT_W(10)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
`ifdef NEURON_SEQ_BIAS_LOAD_EN
    .bias         (bias_v),
`endif
    .io           (nif.slave),
    .alu_in_a_lsb (alu_in_a_lsb),
    .alu_in_b     (alu_in_b),
    .alu_op       (alu_op),
    .alu_out      (alu_out),
    .busy         (busy)
  );

  // ALU: negative operand clamps to 0, then +/-1, wrapping at W bits.
  logic signed [W-1:0] alu_clamp;
  assign alu_clamp = alu_in_b[W-1] ? '0 : alu_in_b;
  assign alu_out   = alu_op ? alu_clamp - {{(W-1){1'b0}}, alu_in_a_lsb}
                            : alu_clamp + {{(W-1){1'b0}}, alu_in_a_lsb};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp,
               $time);
    end
  endtask

  // One neuron step from the arithmetic rules.
  function automatic int step(input int s, input bit x, input bit w);
    int c;
    int r;
    c = (s < 0) ? 0 : s;
    r = (x == w) ? c + 1 : c - 1;
    if (r >= (1 << (W - 1))) r -= (1 << W);
    if (r < -(1 << (W - 1))) r += (1 << W);
    return r;
  endfunction

  function automatic int sext(input logic [W-1:0] v);
    return int'(signed'(v));
  endfunction

  // Monitor: every accepted result pops the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && nif.out_valid && nif.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", sext(nif.out_data), -9999);
      end else begin
        check("result", sext(nif.out_data), exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_eval(input int b, input bit [N-1:0] xv,
                          input bit [N-1:0] wv, input int gap,
                          input int bp, input bit poke);
    int partial;
    int e;
    partial = HAS_BIAS ? b : 0;
    e = partial;
    for (int i = 0; i < N; i++) e = step(e, xv[i], wv[i]);
    exp_q.push_back(e);
    bias_v = W'(b);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    check("in_ready_accum", int'(nif.in_ready), 1);
    for (int i = 0; i < N; i++) begin
      nif.in_valid = 1'b1;
      nif.in_x     = xv[i];
      nif.in_w     = wv[i];
      #1;
      check("alu_in_b", sext(alu_in_b), partial);
      check("alu_op", int'(alu_op), int'(xv[i] ^ wv[i]));
      tick();
      partial = step(partial, xv[i], wv[i]);
      nif.in_valid = 1'b0;
      if (i < N - 1) begin
        for (int g = 0; g < gap; g++) begin
          start = poke && (g == 0);
          tick();
          start = 1'b0;
          check("gap_hold", sext(alu_in_b), partial);
          check("gap_op0", int'(alu_op), 0);
        end
      end
    end
    check("latency_valid", int'(nif.out_valid), 1);
    for (int k = 0; k < bp; k++) begin
      start = poke && (k == 0);
      tick();
      start = 1'b0;
      check("bp_valid", int'(nif.out_valid), 1);
      check("bp_data", sext(nif.out_data), e);
    end
    nif.out_ready = 1'b1;
    start = poke;
    tick();
    nif.out_ready = 1'b0;
    start = 1'b0;
    check("idle_busy", int'(busy), 0);
    check("idle_valid", int'(nif.out_valid), 0);
  endtask

  task automatic check_zero_outs(input string tag);
    check({tag, "_in_ready"}, int'(nif.in_ready), 0);
    check({tag, "_out_valid"}, int'(nif.out_valid), 0);
    check({tag, "_out_data"}, sext(nif.out_data), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_alu_op"}, int'(alu_op), 0);
    check({tag, "_alu_in_b"}, sext(alu_in_b), 0);
  endtask

  initial begin
    rst_n         = 1'b1;
    start         = 1'b0;
    bias_v        = '0;
    nif.in_valid  = 1'b0;
    nif.in_x      = 1'b0;
    nif.in_w      = 1'b0;
    nif.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    tick();
    tick();
    check_zero_outs("reset");
    rst_n = 1'b1;
    tick();

    // All match -> 4
    run_eval(0, 4'b0101, 4'b0101, 0, 0, 1'b0);
    // Mix -> 2 (last pair mismatches)
    run_eval(0, 4'b1111, 4'b0111, 0, 0, 1'b0);
    // All mismatch from 0 -> -1 via clamp
    run_eval(0, 4'b1111, 4'b0000, 0, 0, 1'b0);
    // Bias 5, all mismatch -> 1 (0 without bias feature -> -1)
    run_eval(5, 4'b0000, 4'b1111, 0, 0, 1'b0);
    // Gaps, backpressure and start pokes while busy
    run_eval(0, 4'b1010, 4'b1001, 3, 5, 1'b1);

    // Reset after two accepted pairs
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      nif.in_valid = 1'b1;
      nif.in_x     = 1'b1;
      nif.in_w     = 1'b1;
      tick();
    end
    nif.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero_outs("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    run_eval(0, 4'b0011, 4'b0011, 0, 0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      run_eval(int'($urandom_range(0, 4095)) - 2048,
               4'($urandom), 4'($urandom),
               int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
               1'($urandom));
    end

    tick();
    tick();
    check("queue_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
